// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared widths, latency and arbitration types for the SRAM32768x96 access controller
package sram_ctrl_pkg;

  localparam int ADDRESSSIZE = 15;
  localparam int WORDSIZE    = 96;
  localparam int RA_BITS     = 11;
  localparam int CA_BITS     = 4;
  localparam int SRAM_RD_LAT = 2;

  typedef enum logic {
    ARB_WR = 1'b0,
    ARB_RD = 1'b1
  } arb_sel_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - DEPTH x WIDTH synchronous response FIFO, async active-high reset
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = WORDSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign head   = mem_q[rd_ptr_q];
  assign do_pop = pop & ~empty;

  // The caller only pushes when there is room (or a pop frees the slot this cycle).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram96_access_ctrl.sv
// rtl/sram96_access_ctrl.sv - merges write/read request streams into registered SRAM32768x96 commands
// Define SRAM_CTRL_RR_ARB_EN for round-robin arbitration; default is fixed write priority.
module sram96_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iWrValid,
  output logic                   oWrReady,
  input  logic [ADDRESSSIZE-1:0] iWrAddr,
  input  logic [WORDSIZE-1:0]    iWrData,
  input  logic                   iRdValid,
  output logic                   oRdReady,
  input  logic [ADDRESSSIZE-1:0] iRdAddr,
  output logic                   oRspValid,
  input  logic                   iRspReady,
  output logic [WORDSIZE-1:0]    oRspData,
  output logic                   oNCE,
  output logic                   oNWRT,
  output logic [RA_BITS-1:0]     oRA,
  output logic [CA_BITS-1:0]     oCA,
  output logic [WORDSIZE-1:0]    oDIN,
  input  logic [WORDSIZE-1:0]    iDO
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic                   wr_acc, rd_acc, credit_ok;
  logic                   rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [CNT_W-1:0]       inflight_q, inflight_d;
  logic [SRAM_RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic                   nce_q, nce_d;
  logic                   nwrt_q, nwrt_d;
  logic [RA_BITS-1:0]     ra_q, ra_d;
  logic [CA_BITS-1:0]     ca_q, ca_d;
  logic [WORDSIZE-1:0]    din_q, din_d;

  // inflight counts reads issued but not yet popped, so the FIFO can never be oversubscribed.
  assign credit_ok = (inflight_q < CNT_W'(RSP_DEPTH));
  assign wr_acc    = iWrValid & oWrReady;
  assign rd_acc    = iRdValid & oRdReady;

`ifdef SRAM_CTRL_RR_ARB_EN
  // ptr_q names the stream that wins the next contested cycle; a credit-starved read forfeits nothing.
  arb_sel_e ptr_q, ptr_d;
  logic     rd_elig;

  assign rd_elig  = iRdValid & credit_ok;
  assign oWrReady = ~(rd_elig & (ptr_q == ARB_RD));
  assign oRdReady = credit_ok & (~iWrValid | (ptr_q == ARB_RD));

  always_comb begin
    ptr_d = ptr_q;
    if (wr_acc) begin
      ptr_d = ARB_RD;
    end else if (rd_acc) begin
      ptr_d = ARB_WR;
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      ptr_q <= ARB_WR;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign oWrReady = 1'b1;
  assign oRdReady = credit_ok & ~iWrValid;
`endif

  always_comb begin
    nce_d  = 1'b1;
    nwrt_d = 1'b1;
    ra_d   = ra_q;
    ca_d   = ca_q;
    din_d  = din_q;
    if (wr_acc) begin
      nce_d  = 1'b0;
      nwrt_d = 1'b0;
      ra_d   = iWrAddr[ADDRESSSIZE-1:CA_BITS];
      ca_d   = iWrAddr[CA_BITS-1:0];
      din_d  = iWrData;
    end else if (rd_acc) begin
      nce_d = 1'b0;
      ra_d  = iRdAddr[ADDRESSSIZE-1:CA_BITS];
      ca_d  = iRdAddr[CA_BITS-1:0];
    end
  end

  // Top bit of the shift marks the cycle in which iDO carries the data of an earlier read.
  assign rd_pipe_d = {rd_pipe_q[SRAM_RD_LAT-2:0], rd_acc};
  assign rsp_pop   = oRspValid & iRspReady;
  assign rsp_push  = rd_pipe_q[SRAM_RD_LAT-1] & (~rsp_full | rsp_pop);

  always_comb begin
    case ({rd_acc, rsp_pop})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      nce_q      <= 1'b1;
      nwrt_q     <= 1'b1;
      ra_q       <= '0;
      ca_q       <= '0;
      din_q      <= '0;
      rd_pipe_q  <= '0;
      inflight_q <= '0;
    end else begin
      nce_q      <= nce_d;
      nwrt_q     <= nwrt_d;
      ra_q       <= ra_d;
      ca_q       <= ca_d;
      din_q      <= din_d;
      rd_pipe_q  <= rd_pipe_d;
      inflight_q <= inflight_d;
    end
  end

  assign oNCE      = nce_q;
  assign oNWRT     = nwrt_q;
  assign oRA       = ra_q;
  assign oCA       = ca_q;
  assign oDIN      = din_q;
  assign oRspValid = ~rsp_empty;

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (WORDSIZE)
  ) u_rsp_fifo (
    .clk       (iClk),
    .rst       (iReset),
    .push      (rsp_push),
    .push_data (iDO),
    .pop       (rsp_pop),
    .full      (rsp_full),
    .empty     (rsp_empty),
    .head      (oRspData)
  );

endmodule
